// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry, FSM state type and address field helpers for
// the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int TAG_W      = 22;
  localparam int IDX_W      = 5;
  localparam int LINE_W     = 256;
  localparam int WORD_SEL_W = 3;
  localparam int NUM_LINES  = 32;
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:10];
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] addr);
    return addr[9:5];
  endfunction

  function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [31:0] addr);
    return addr[4:2];
  endfunction

  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                            input logic [IDX_W-1:0] index);
    return {tag, index, 5'b00000};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: per-line valid/dirty/tag/data storage. Reads are combinational
// by index; a full-line write installs a clean valid line, a word write merges
// one 32-bit word and marks the line dirty. Reset clears only valid and dirty.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_W-1:0]      index,
  input  logic                  line_we,
  input  logic [TAG_W-1:0]      line_tag,
  input  logic [LINE_W-1:0]     line_data,
  input  logic                  word_we,
  input  logic [WORD_SEL_W-1:0] word_sel,
  input  logic [WORD_W-1:0]     word_data,
  output logic                  valid,
  output logic                  dirty,
  output logic [TAG_W-1:0]      tag,
  output logic [LINE_W-1:0]     data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  // Line status bits: a refill installs a clean line, a store dirties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tag and data payload; contents are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[index]  <= line_tag;
      data_q[index] <= line_data;
    end else if (word_we) begin
      data_q[index][{word_sel, 5'b00000} +: WORD_W] <= word_data;
    end
  end

  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag   = tag_q[index];
  assign data  = data_q[index];

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate data cache.
// Misses stall the CPU while a dirty victim is written back and the line is
// refilled over the enable/write/ack memory handshake.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          p1_req_i,
  input  logic          p1_write_i,
  input  logic [31:0]   p1_addr_i,
  input  logic [31:0]   p1_data_i,
  output logic [31:0]   p1_data_o,
  output logic          p1_stall_o,
  output logic          mem_enable_o,
  output logic          mem_write_o,
  output logic [31:0]   mem_addr_o,
  output logic [255:0]  mem_data_o,
  input  logic          mem_ack_i,
  input  logic [255:0]  mem_data_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]   hit_count_o,
  output logic [31:0]   miss_count_o
`endif
);

  state_t                state;
  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_index;
  logic [WORD_SEL_W-1:0] req_word;
  logic                  line_valid;
  logic                  line_dirty;
  logic [TAG_W-1:0]      line_tag;
  logic [LINE_W-1:0]     line_data;
  logic                  hit;
  logic                  idle;
  logic                  line_we;
  logic                  word_we;
  logic                  unused_addr_lsb;

  assign req_tag   = addr_tag(p1_addr_i);
  assign req_index = addr_index(p1_addr_i);
  assign req_word  = addr_word(p1_addr_i);
  assign unused_addr_lsb = ^p1_addr_i[1:0];

  assign idle    = (state == ST_IDLE);
  assign hit     = line_valid && (line_tag == req_tag);
  assign line_we = (state == ST_REFILL) && mem_ack_i;
  assign word_we = idle && p1_req_i && p1_write_i && hit;

  assign p1_stall_o = p1_req_i && (!idle || !hit);
  assign p1_data_o  = hit ? line_data[{req_word, 5'b00000} +: WORD_W] : '0;

  dcache_sram u_sram (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .index     (req_index),
    .line_we   (line_we),
    .line_tag  (req_tag),
    .line_data (mem_data_i),
    .word_we   (word_we),
    .word_sel  (req_word),
    .word_data (p1_data_i),
    .valid     (line_valid),
    .dirty     (line_dirty),
    .tag       (line_tag),
    .data      (line_data)
  );

  // Miss FSM with registered memory-side outputs; address/data are loaded on
  // entry to a transaction so they are stable for the whole enable window.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          mem_enable_o <= 1'b0;
          if (p1_req_i && !hit) begin
            if (line_valid && line_dirty) begin
              state       <= ST_WRITEBACK;
              mem_write_o <= 1'b1;
              mem_addr_o  <= line_addr(line_tag, req_index);
              mem_data_o  <= line_data;
            end else begin
              state       <= ST_REFILL;
              mem_write_o <= 1'b0;
              mem_addr_o  <= line_addr(req_tag, req_index);
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ack_i) begin
            mem_enable_o <= 1'b0;
            state        <= ST_REFILL;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= line_addr(req_tag, req_index);
          end else begin
            mem_enable_o <= 1'b1;
          end
        end
        ST_REFILL: begin
          if (mem_ack_i) begin
            mem_enable_o <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            mem_enable_o <= 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          mem_enable_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic refilled;

  // Hit/miss statistics; the completion right after a refill is not a hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
      refilled     <= 1'b0;
    end else begin
      if (line_we) begin
        refilled <= 1'b1;
      end else if (idle) begin
        refilled <= 1'b0;
      end
      if (idle && p1_req_i) begin
        if (hit) begin
          if (!refilled) begin
            hit_count_o <= hit_count_o + 32'd1;
          end
        end else begin
          miss_count_o <= miss_count_o + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed plus randomized accesses against a
// behavioural cache/memory model held in the bench.
module tb_dcache_controller;

  logic         clk;
  logic         rst_n;
  logic         p1_req;
  logic         p1_write;
  logic [31:0]  p1_addr;
  logic [31:0]  p1_wdata;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_ack;
  logic [255:0] mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count_o;
  logic [31:0]  miss_count_o;
`endif

  int checks;
  int failures;

  // Reference model: cache contents and backing memory keyed by line number.
  logic         mv   [32];
  logic         md   [32];
  logic [21:0]  mt   [32];
  logic [255:0] mdat [32];
  logic [255:0] bmem [logic [26:0]];
  int           hit_exp;
  int           miss_exp;

  dcache_controller dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .p1_req_i     (p1_req),
    .p1_write_i   (p1_write),
    .p1_addr_i    (p1_addr),
    .p1_data_i    (p1_wdata),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_ack_i    (mem_ack),
    .mem_data_i   (mem_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count_o  (hit_count_o),
    .miss_count_o (miss_count_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (failures=%0d)", failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] get_line(input logic [26:0] ln);
    logic [255:0] v;
    if (!bmem.exists(ln)) begin
      for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
      bmem[ln] = v;
    end
    return bmem[ln];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
      mt[i] = '0;
      mdat[i] = '0;
    end
    hit_exp  = 0;
    miss_exp = 0;
  endtask

  // One CPU access, serving the memory side with the given latencies
  // (number of enable-high cycles before the ack cycle).
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat_wb, input int lat_rf);
    logic [4:0]   idx;
    logic [21:0]  tg;
    logic [2:0]   w;
    logic         exp_hit;
    logic         exp_wb;
    logic [31:0]  t_addr [2];
    logic         t_wr   [2];
    logic [255:0] t_data [2];
    int           t_lat  [2];
    int           ntx, cur, en_cnt, stalls, exp_stalls;
    logic         gap;
    logic [255:0] ln;

    idx = addr[9:5];
    tg  = addr[31:10];
    w   = addr[4:2];
    exp_hit = mv[idx] && (mt[idx] == tg);
    exp_wb  = !exp_hit && mv[idx] && md[idx];
    ntx = 0;
    if (exp_wb) begin
      t_addr[0] = {mt[idx], idx, 5'b0};
      t_wr[0]   = 1'b1;
      t_data[0] = mdat[idx];
      t_lat[0]  = lat_wb;
      ntx = 1;
    end
    if (!exp_hit) begin
      t_addr[ntx] = {tg, idx, 5'b0};
      t_wr[ntx]   = 1'b0;
      t_data[ntx] = '0;
      t_lat[ntx]  = lat_rf;
      ntx++;
    end
    exp_stalls = exp_hit ? 0 : (exp_wb ? lat_wb + lat_rf + 5 : lat_rf + 3);

    @(negedge clk);
    p1_req   = 1'b1;
    p1_write = wr;
    p1_addr  = addr;
    p1_wdata = wdata;
    cur = 0;
    en_cnt = 0;
    stalls = 0;
    gap = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      #1;
      if (!p1_stall_o) break;
      stalls++;
      if (gap) begin
        check("enable_gap", {255'b0, mem_enable_o}, 256'd0);
        gap = 1'b0;
      end
      if (mem_enable_o) begin
        if (cur < ntx) begin
          check("mem_addr", {224'b0, mem_addr_o}, {224'b0, t_addr[cur]});
          if (en_cnt == 0) begin
            check("mem_write", {255'b0, mem_write_o}, {255'b0, t_wr[cur]});
            if (t_wr[cur]) check("mem_wb_data", mem_data_o, t_data[cur]);
          end
          if (en_cnt == t_lat[cur]) begin
            mem_ack = 1'b1;
            if (t_wr[cur]) bmem[t_addr[cur][31:5]] = mem_data_o;
            else mem_rdata = get_line(t_addr[cur][31:5]);
          end
          en_cnt++;
        end else begin
          check("extra_mem_txn", {255'b0, mem_enable_o}, 256'd0);
        end
      end
      @(posedge clk);
      if (mem_ack) begin
        cur++;
        en_cnt = 0;
        gap = 1'b1;
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    check("stall_cycles", stalls, exp_stalls);
    check("txn_count", cur, ntx);
    if (exp_hit) check("hit_no_mem", {255'b0, mem_enable_o}, 256'd0);

    if (exp_hit) hit_exp++;
    else miss_exp++;
    if (!exp_hit) begin
      ln = get_line({tg, idx});
      mv[idx]   = 1'b1;
      md[idx]   = 1'b0;
      mt[idx]   = tg;
      mdat[idx] = ln;
    end
    if (!wr) begin
      check("load_data", {224'b0, p1_data_o}, {224'b0, mdat[idx][32*w +: 32]});
    end else begin
      mdat[idx][32*w +: 32] = wdata;
      md[idx] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    p1_req = 1'b0;
  endtask

  initial begin
    logic [255:0] pre;
    int           waited;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    p1_req   = 1'b0;
    p1_write = 1'b0;
    p1_addr  = '0;
    p1_wdata = '0;
    mem_ack  = 1'b0;
    mem_rdata = '0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_enable", {255'b0, mem_enable_o}, 256'd0);
    check("rst_write",  {255'b0, mem_write_o}, 256'd0);
    check("rst_addr",   {224'b0, mem_addr_o}, 256'd0);
    check("rst_data",   mem_data_o, 256'd0);
    check("rst_p1_data", {224'b0, p1_data_o}, 256'd0);
    check("rst_stall",  {255'b0, p1_stall_o}, 256'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) pre[32*k +: 32] = $urandom;
    pre[31:0] = 32'h11111111;
    bmem[27'h2] = pre;

    access(1'b0, 32'h00000040, 32'h0, 0, 2);
    access(1'b0, 32'h00000044, 32'h0, 0, 0);
    access(1'b1, 32'h00000048, 32'hDEADBEEF, 0, 0);
    access(1'b0, 32'h00000048, 32'h0, 0, 0);
    check("wb_word2", {224'b0, mdat[2][95:64]}, {224'b0, 32'hDEADBEEF});
    access(1'b0, 32'h00000448, 32'h0, 1, 2);
    check("mem_wb_word2", {224'b0, bmem[27'h2][95:64]}, {224'b0, 32'hDEADBEEF});
`ifdef DCACHE_STATS_EN
    check("miss_count", {224'b0, miss_count_o}, 256'd2);
    check("hit_count",  {224'b0, hit_count_o}, 256'd3);
`endif

    access(1'b0, 32'h00000848, 32'h0, 0, 40);

    // Reset in the middle of a refill.
    @(negedge clk);
    p1_req   = 1'b1;
    p1_write = 1'b0;
    p1_addr  = 32'h00000040;
    waited = 0;
    #1;
    while (!mem_enable_o && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("mid_refill_enable", {255'b0, mem_enable_o}, 256'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_enable", {255'b0, mem_enable_o}, 256'd0);
    check("async_rst_stall",  {255'b0, p1_stall_o}, 256'd1);
    model_reset();
    @(negedge clk);
    p1_req = 1'b0;
    rst_n  = 1'b1;
    access(1'b0, 32'h00000040, 32'h0, 0, 1);
    check("reload_word0", {224'b0, mdat[2][31:0]}, {224'b0, 32'h11111111});

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = '0;
      a[11:10] = 2'($urandom_range(0, 3));
      a[6:5]   = 2'($urandom_range(0, 3));
      a[4:2]   = 3'($urandom_range(0, 7));
      access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end
`ifdef DCACHE_STATS_EN
    check("final_miss_count", {224'b0, miss_count_o}, miss_exp);
    check("final_hit_count",  {224'b0, hit_count_o}, hit_exp);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache controller placed between the CPU data port and the 256-bit line-based data memory. It serves 32-bit word loads and stores from a 32-line × 32-byte array. Misses are handled by acting as initiator on the memory's enable/write/ack handshake: dirty-victim writeback first, then line refill. The CPU is stalled until the access completes.

## Interface
- No parameters. Geometry is fixed by package constants.
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- p1_req_i  in  1  CPU access request
- p1_write_i  in  1  1 = store, 0 = load
- p1_addr_i  in  32  byte address, word-aligned
- p1_data_i  in  32  store data
- p1_data_o  out  32  load data, valid when p1_req_i && !p1_stall_o
- p1_stall_o  out  1  CPU must hold request
- mem_enable_o  out  1  memory transaction request
- mem_write_o  out  1  1 = line write, 0 = line read
- mem_addr_o  out  32  line address, bits [4:0] = 0
- mem_data_o  out  256  writeback line
- mem_ack_i  in  1  single-cycle completion pulse
- mem_data_i  in  256  refill line, valid while mem_ack_i = 1
- hit_count_o, miss_count_o  out  32  present only with DCACHE_STATS_EN

## Operation
- Address fields: offset [4:0], word select [4:2], index [9:5], tag [31:10] (22 bits).
- Per line state: valid, dirty, tag, 256-bit data. Word w occupies data[32w+31:32w].
- hit = valid[index] && tag[index] == addr tag.
- States: IDLE, WRITEBACK, REFILL.
- IDLE, p1_req_i, hit:
  - Load: p1_data_o = selected word, combinational.
  - Store: merge word at edge, set dirty. No stall.
- IDLE, p1_req_i, miss: next state WRITEBACK if the victim is valid and dirty, else REFILL.
- WRITEBACK:
  - mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line.
  - On mem_ack_i: next state REFILL.
- REFILL:
  - mem_write_o = 0, mem_addr_o = {req tag, index, 5'b0}.
  - On mem_ack_i: write mem_data_i, tag, valid = 1, dirty = 0. Next state IDLE.
  - The request is then re-evaluated as a hit. A store merges at that point.
- p1_stall_o = p1_req_i && (state != IDLE || !hit), combinational.
- mem_enable_o is registered:
  - Set at each edge in WRITEBACK or REFILL where mem_ack_i = 0.
  - Cleared at the edge where mem_ack_i is sampled, and in IDLE.
  - This guarantees at least one low cycle between consecutive transactions.
- mem_addr_o, mem_write_o and mem_data_o stay stable while mem_enable_o = 1.
- p1 inputs must stay stable while stalled. The controller does not latch them.

## Timing
- Reset values:
  - state IDLE; all valid and dirty bits 0.
  - mem_enable_o 0, mem_write_o 0, mem_addr_o 0, mem_data_o 0.
  - p1_data_o 0 while no hit; counters 0.
- Hit latency: 0 cycles, same-cycle completion.
- Clean miss: one edge IDLE→REFILL, one edge to raise enable, then the memory latency L, ack edge, one edge IDLE completion. Stall = L + 3 cycles.
- Dirty miss adds the writeback transaction plus its enable-raise cycle.
- No timeout. Enable is held indefinitely until ack arrives.
- mem_ack_i outside WRITEBACK/REFILL is ignored.
- p1_req_i dropping mid-miss: the transaction still completes and the line is installed.
- Reset mid-transaction: mem_enable_o drops asynchronously and the array is invalidated. The in-flight memory response is discarded.

## Configuration
- DCACHE_STATS_EN defined:
  - hit_count_o increments once per request completing in IDLE without having missed.
  - miss_count_o increments on each IDLE→WRITEBACK/REFILL transition.
  - A post-refill completion is not counted as a hit, tracked by a 1-bit refilled flag.
  - Counters wrap modulo 2^32.
- Undefined: ports, counters and flag are absent; behaviour is otherwise identical.

## Structure
- Package dcache_pkg:
  - state enum.
  - TAG_W = 22, IDX_W = 5, LINE_W = 256, WORD_SEL_W = 3, NUM_LINES = 32.
  - Field-extract functions.
- Sub-module dcache_sram: tag/valid/dirty/data array.
  - Combinational read by index.
  - Synchronous write with full-line write and single-word merge enables.
  - Async reset clears valid and dirty only.

## Test plan
- After reset, load 0x00000040 → REFILL with mem_addr_o 0x40, mem_write_o 0. Ack with word0 = 0x11111111 → stall drops, p1_data_o = 0x11111111, no writeback.
- Load 0x00000044 next → stall 0 same cycle, word1 returned, mem_enable_o stays 0.
- Store 0xDEADBEEF to 0x00000048 → no memory access; a following load of 0x48 returns 0xDEADBEEF.
- Load 0x00000448 (index 2, tag 1) → WRITEBACK to 0x40 with mem_data_o[95:64] = 0xDEADBEEF, enable low one cycle, REFILL at 0x440, then hit.
- Ack delayed 40 cycles → enable and stall held throughout. rst_i low mid-REFILL → enable 0 immediately, and a re-load of 0x40 misses again.
- With DCACHE_STATS_EN, the sequence above → miss_count_o = 2, hit_count_o = 3.
